// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator CPU core: FSM states, opcodes, flag bit positions.
package acc_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXEC    = 2'd1,
    ST_WAIT_IN = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP    = 4'h0,
    OP_LDI    = 4'h1,
    OP_ADDI   = 4'h2,
    OP_SUBI   = 4'h3,
    OP_NANDI  = 4'h4,
    OP_SHL    = 4'h5,
    OP_SHR    = 4'h6,
    OP_IN     = 4'h7,
    OP_OUT    = 4'h8,
    OP_JMP    = 4'h9,
    OP_JZ     = 4'hA,
    OP_JC     = 4'hB,
    OP_JNZ    = 4'hC,
    OP_RSVD_D = 4'hD,
    OP_RSVD_E = 4'hE,
    OP_HLT    = 4'hF
  } opcode_t;

  // Bit positions inside the {C, Z} flags vector
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;

endpackage

// File: rtl/acc_alu.sv
// Combinational ALU for the accumulator core; reports which architectural state each op writes.
module acc_alu
  import acc_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  opcode_t           op,
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] imm,
  input  logic              c,
  output logic [DATA_W-1:0] result,
  output logic              c_next,
  output logic              z_next,
  output logic              writes_acc,
  output logic              writes_c
);

  logic [DATA_W:0] wide;

  // Compute the accumulator result and flag updates for opcodes 1..6
  always_comb begin
    result     = acc;
    c_next     = c;
    writes_acc = 1'b0;
    writes_c   = 1'b0;
    wide       = '0;
    case (op)
      OP_LDI: begin
        result     = imm;
        writes_acc = 1'b1;
      end
      OP_ADDI: begin
        wide       = {1'b0, acc} + {1'b0, imm};
        result     = wide[DATA_W-1:0];
        c_next     = wide[DATA_W];
        writes_acc = 1'b1;
        writes_c   = 1'b1;
      end
      OP_SUBI: begin
        // top bit of the widened difference is the borrow (acc < imm)
        wide       = {1'b0, acc} - {1'b0, imm};
        result     = wide[DATA_W-1:0];
        c_next     = wide[DATA_W];
        writes_acc = 1'b1;
        writes_c   = 1'b1;
      end
      OP_NANDI: begin
        result     = ~(acc & imm);
        writes_acc = 1'b1;
      end
      OP_SHL: begin
        result     = {acc[DATA_W-2:0], 1'b0};
        c_next     = acc[DATA_W-1];
        writes_acc = 1'b1;
        writes_c   = 1'b1;
      end
      OP_SHR: begin
        result     = {1'b0, acc[DATA_W-1:1]};
        c_next     = acc[0];
        writes_acc = 1'b1;
        writes_c   = 1'b1;
      end
      default: ;
    endcase
    z_next = (result == '0);
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core: FETCH/EXEC/WAIT_IN/HALT sequencing, PC, IR, ACC and I/O registers.
module acc_cpu_core
  import acc_pkg::*;
#(
  parameter  int unsigned DATA_W = 8,
  parameter  int unsigned ADDR_W = 12,
  localparam int unsigned INS_W  = 4 + ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [INS_W-1:0]  imem_ins_i,
  input  logic              imem_ack_i,
  input  logic [DATA_W-1:0] aib_i,
  input  logic              aib_valid_i,
  output logic              aib_ready_o,
  output logic [DATA_W-1:0] aob_o,
  output logic              aob_valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INS_W-1:0]  ins_o,
  output logic [1:0]        flags_o,
  output logic [1:0]        state_o,
  output logic              halted_o
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [INS_W-1:0]  ins;
  logic [DATA_W-1:0] acc;
  logic              c_flag;
  logic              z_flag;
  logic [DATA_W-1:0] aob;
  logic              aob_valid;
  logic              aib_ready;
  logic              imem_req;
  logic              halted;

  opcode_t           op;
  logic [ADDR_W-1:0] operand;
  logic [ADDR_W-1:0] pc_inc;
  logic [DATA_W-1:0] alu_result;
  logic              alu_c;
  logic              alu_z;
  logic              alu_writes_acc;
  logic              alu_writes_c;

  assign op      = opcode_t'(ins[INS_W-1 -: 4]);
  assign operand = ins[ADDR_W-1:0];
  assign pc_inc  = pc + ADDR_W'(1);

  acc_alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op        (op),
    .acc       (acc),
    .imm       (ins[DATA_W-1:0]),
    .c         (c_flag),
    .result    (alu_result),
    .c_next    (alu_c),
    .z_next    (alu_z),
    .writes_acc(alu_writes_acc),
    .writes_c  (alu_writes_c)
  );

  // FSM with registered handshake outputs; each state sets req/ready/halted for the state it enters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= ST_FETCH;
      pc        <= '0;
      ins       <= '0;
      acc       <= '0;
      c_flag    <= 1'b0;
      z_flag    <= 1'b0;
      aob       <= '0;
      aob_valid <= 1'b0;
      aib_ready <= 1'b0;
      imem_req  <= 1'b1;
      halted    <= 1'b0;
    end else begin
      aob_valid <= 1'b0;
      unique case (state)
        ST_FETCH: begin
          if (imem_ack_i) begin
            ins      <= imem_ins_i;
            imem_req <= 1'b0;
            state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          state    <= ST_FETCH;
          imem_req <= 1'b1;
          pc       <= pc_inc;
          if (alu_writes_acc) begin
            acc    <= alu_result;
            z_flag <= alu_z;
          end
          if (alu_writes_c) begin
            c_flag <= alu_c;
          end
          case (op)
            OP_IN: begin
              // PC advances only once the input transfer completes
              pc        <= pc;
              imem_req  <= 1'b0;
              aib_ready <= 1'b1;
              state     <= ST_WAIT_IN;
            end
            OP_OUT: begin
              aob       <= acc;
              aob_valid <= 1'b1;
            end
            OP_JMP: pc <= operand;
            OP_JZ:  if (z_flag)  pc <= operand;
            OP_JC:  if (c_flag)  pc <= operand;
            OP_JNZ: if (!z_flag) pc <= operand;
            OP_HLT: begin
              pc       <= pc;
              imem_req <= 1'b0;
              halted   <= 1'b1;
              state    <= ST_HALT;
            end
            default: ;
          endcase
        end
        ST_WAIT_IN: begin
          if (aib_valid_i && aib_ready) begin
            acc       <= aib_i;
            z_flag    <= (aib_i == '0);
            pc        <= pc_inc;
            aib_ready <= 1'b0;
            imem_req  <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_HALT: ;
      endcase
    end
  end

  // Pack the flag bits into the {C, Z} output vector
  always_comb begin
    flags_o         = '0;
    flags_o[FLAG_C] = c_flag;
    flags_o[FLAG_Z] = z_flag;
  end

  assign imem_req_o  = imem_req;
  assign imem_addr_o = pc;
  assign aib_ready_o = aib_ready;
  assign aob_o       = aob;
  assign aob_valid_o = aob_valid;
  assign pc_o        = pc;
  assign ins_o       = ins;
  assign state_o     = state;
  assign halted_o    = halted;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed self-checking bench for acc_cpu_core: default 8/12 instance plus a 4/8 instance.
module tb_acc_cpu_core;
  import acc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-width instance
  logic        rst_n;
  logic        req;
  logic [11:0] addr;
  logic [15:0] ins_i;
  logic        ack;
  logic [7:0]  aib;
  logic        aib_valid;
  logic        aib_ready;
  logic [7:0]  aob;
  logic        aob_valid;
  logic [11:0] pc;
  logic [15:0] ins_o;
  logic [1:0]  flags;
  logic [1:0]  state;
  logic        halted;
  logic [15:0] mem [4096];
  assign ins_i = mem[addr];

  acc_cpu_core u_dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .imem_req_o (req),
    .imem_addr_o(addr),
    .imem_ins_i (ins_i),
    .imem_ack_i (ack),
    .aib_i      (aib),
    .aib_valid_i(aib_valid),
    .aib_ready_o(aib_ready),
    .aob_o      (aob),
    .aob_valid_o(aob_valid),
    .pc_o       (pc),
    .ins_o      (ins_o),
    .flags_o    (flags),
    .state_o    (state),
    .halted_o   (halted)
  );

  // Narrow instance: DATA_W=4, ADDR_W=8
  logic        rst2_n;
  logic        req2;
  logic [7:0]  addr2;
  logic [11:0] ins2_i;
  logic        ack2;
  logic [3:0]  aib2;
  logic        aib_valid2;
  logic        aib_ready2;
  logic [3:0]  aob2;
  logic        aob_valid2;
  logic [7:0]  pc2;
  logic [11:0] ins2_o;
  logic [1:0]  flags2;
  logic [1:0]  state2;
  logic        halted2;
  logic [11:0] mem2 [256];
  assign ins2_i = mem2[addr2];

  acc_cpu_core #(
    .DATA_W(4),
    .ADDR_W(8)
  ) u_dut4 (
    .clk_i      (clk),
    .rst_ni     (rst2_n),
    .imem_req_o (req2),
    .imem_addr_o(addr2),
    .imem_ins_i (ins2_i),
    .imem_ack_i (ack2),
    .aib_i      (aib2),
    .aib_valid_i(aib_valid2),
    .aib_ready_o(aib_ready2),
    .aob_o      (aob2),
    .aob_valid_o(aob_valid2),
    .pc_o       (pc2),
    .ins_o      (ins2_o),
    .flags_o    (flags2),
    .state_o    (state2),
    .halted_o   (halted2)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One zero-wait non-IN instruction is two cycles
  task automatic run_ins(input int n);
    step(2 * n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    ack = 1'b1; aib = '0; aib_valid = 1'b0;
    ack2 = 1'b1; aib2 = '0; aib_valid2 = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 256; i++) mem2[i] = '0;

    // ---- ALU, flags, branches, wrap ----
    mem[12'h000] = 16'h10FF; mem[12'h001] = 16'h2001; mem[12'h002] = 16'h8000;
    mem[12'h003] = 16'h3001; mem[12'h004] = 16'h8000; mem[12'h005] = 16'h6000;
    mem[12'h006] = 16'h8000; mem[12'h007] = 16'h400F; mem[12'h008] = 16'h5000;
    mem[12'h009] = 16'h8000; mem[12'h00A] = 16'h1000; mem[12'h00B] = 16'hA100;
    mem[12'h100] = 16'h1001; mem[12'h101] = 16'hA200; mem[12'h102] = 16'hB020;
    mem[12'h020] = 16'hC030; mem[12'h030] = 16'h8000; mem[12'h031] = 16'h9FFF;
    mem[12'hFFF] = 16'h0000;

    #12;
    check("rst_pc", pc, 0);
    check("rst_ins", ins_o, 0);
    check("rst_flags", flags, 0);
    check("rst_state", state, ST_FETCH);
    check("rst_aob", aob, 0);
    check("rst_aob_valid", aob_valid, 0);
    check("rst_ready", aib_ready, 0);
    check("rst_halted", halted, 0);
    rst_n = 1'b1;
    #1;
    check("first_req", req, 1);

    step(1);
    check("fetch_ins", ins_o, 16'h10FF);
    check("fetch_state", state, ST_EXEC);
    step(1);
    check("ldi_flags", flags, 2'b00);
    check("ldi_pc", pc, 1);
    run_ins(1);
    check("addi_flags", flags, 2'b11);
    check("addi_pc", pc, 2);
    run_ins(1);
    check("out0_valid", aob_valid, 1);
    check("out0_aob", aob, 8'h00);
    step(1);
    check("out0_strobe_end", aob_valid, 0);
    step(1);
    check("subi_flags", flags, 2'b10);
    run_ins(1);
    check("out1_aob", aob, 8'hFF);
    step(2);
    check("shr_flags", flags, 2'b10);
    run_ins(1);
    check("out2_aob", aob, 8'h7F);
    step(2);
    check("nandi_flags", flags, 2'b10);
    run_ins(1);
    check("shl_flags", flags, 2'b10);
    run_ins(1);
    check("out3_aob", aob, 8'hE0);
    step(2);
    check("ldi0_flags", flags, 2'b11);
    run_ins(1);
    check("jz_taken_pc", pc, 12'h100);
    run_ins(1);
    check("ldi1_flags", flags, 2'b10);
    run_ins(1);
    check("jz_not_taken_pc", pc, 12'h102);
    run_ins(1);
    check("jc_taken_pc", pc, 12'h020);
    run_ins(1);
    check("jnz_taken_pc", pc, 12'h030);
    run_ins(1);
    check("out4_valid", aob_valid, 1);
    check("out4_aob", aob, 8'h01);
    step(1);
    check("out4_strobe_end", aob_valid, 0);
    step(1);
    check("jmp_pc", pc, 12'hFFF);
    run_ins(1);
    check("pc_wrap", pc, 12'h000);

    // ---- Delayed ack, IN handshake, reset during WAIT_IN ----
    rst_n = 1'b0;
    ack = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'h000] = 16'h7000; mem[12'h001] = 16'h7000;
    mem[12'h002] = 16'h8000; mem[12'h003] = 16'h7000;
    #1;
    check("rst2_aob", aob, 0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("ackwait_state", state, ST_FETCH);
      check("ackwait_req", req, 1);
      check("ackwait_addr", addr, 0);
    end
    ack = 1'b1;
    step(1);
    check("ack_state", state, ST_EXEC);
    check("ack_ins", ins_o, 16'h7000);
    step(1);
    check("in_state", state, ST_WAIT_IN);
    check("in_ready_first", aib_ready, 1);
    check("in_pc_held", pc, 0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("in_ready_held", aib_ready, 1);
      check("in_state_held", state, ST_WAIT_IN);
    end
    aib = 8'h00; aib_valid = 1'b1;
    step(1);
    aib_valid = 1'b0;
    check("in0_state", state, ST_FETCH);
    check("in0_pc", pc, 1);
    check("in0_flags", flags, 2'b01);
    check("in0_ready_drop", aib_ready, 0);
    step(2);
    check("in1_ready", aib_ready, 1);
    aib = 8'h3C; aib_valid = 1'b1;
    step(1);
    aib_valid = 1'b0;
    check("in1_flags", flags, 2'b00);
    check("in1_pc", pc, 2);
    run_ins(1);
    check("out_in_valid", aob_valid, 1);
    check("out_in_aob", aob, 8'h3C);
    step(1);
    check("out_in_strobe_end", aob_valid, 0);
    step(1);
    check("in2_state", state, ST_WAIT_IN);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_state", state, ST_FETCH);
    check("midrst_ready", aib_ready, 0);
    check("midrst_pc", pc, 0);
    check("midrst_ins", ins_o, 0);
    check("midrst_aob", aob, 0);
    check("midrst_req", req, 1);
    check("midrst_halted", halted, 0);

    // ---- Halt ----
    mem[12'h000] = 16'h9010; mem[12'h010] = 16'hF000;
    rst_n = 1'b1;
    run_ins(1);
    check("jmp_halt_pc", pc, 12'h010);
    run_ins(1);
    check("hlt_halted", halted, 1);
    check("hlt_state", state, ST_HALT);
    check("hlt_pc", pc, 12'h010);
    check("hlt_req", req, 0);
    step(5);
    check("hlt_hold_pc", pc, 12'h010);
    check("hlt_hold_req", req, 0);
    check("hlt_hold_ready", aib_ready, 0);
    check("hlt_hold_halted", halted, 1);

    // ---- Narrow instance ----
    mem2[8'h00] = 12'h10F; mem2[8'h01] = 12'h201; mem2[8'h02] = 12'h301;
    mem2[8'h03] = 12'h600; mem2[8'h04] = 12'h800; mem2[8'h05] = 12'h108;
    mem2[8'h06] = 12'h500; mem2[8'h07] = 12'hF00;
    rst2_n = 1'b1;
    step(1);
    check("w4_ins", ins2_o, 12'h10F);
    step(1);
    check("w4_ldi_flags", flags2, 2'b00);
    run_ins(1);
    check("w4_addi_flags", flags2, 2'b11);
    run_ins(1);
    check("w4_subi_flags", flags2, 2'b10);
    run_ins(1);
    check("w4_shr_flags", flags2, 2'b10);
    run_ins(1);
    check("w4_out_valid", aob_valid2, 1);
    check("w4_out_aob", aob2, 4'h7);
    run_ins(1);
    check("w4_ldi8_flags", flags2, 2'b10);
    run_ins(1);
    check("w4_shl_flags", flags2, 2'b11);
    run_ins(1);
    check("w4_hlt_halted", halted2, 1);
    check("w4_hlt_pc", pc2, 8'h07);
    check("w4_hlt_addr", addr2, 8'h07);
    check("w4_hlt_state", state2, ST_HALT);
    check("w4_hlt_req", req2, 0);
    check("w4_hlt_ready", aib_ready2, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
